// File: rtl/commit_pkg.sv
// commit_pkg: shared instruction-buffer entry types and commit FSM states.
package commit_pkg;
  localparam int BUF_SIZE = 8;
  localparam int IDX_W = $clog2(BUF_SIZE);
  typedef logic [3:0] tag_t;
  typedef logic [IDX_W-1:0] index_t;
  typedef enum logic [1:0] {S_NOT_USED, S_WAITING, S_EXECUTING, S_EXECUTED} e_state_t;
  typedef enum logic [2:0] {ALU, MUL, LOAD, STORE, BRANCH} unit_t;
  typedef enum logic {IDLE, STORE_WAIT} commit_state_t;
  typedef struct packed {
    e_state_t    e_state;
    tag_t        tag;
    logic [5:0]  speculative_tag;
    unit_t       unit;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] vk;
  } entry_t;
  function automatic logic retirable(entry_t e);
    return e.e_state == S_EXECUTED && e.speculative_tag == 6'd0;
  endfunction
endpackage

// File: rtl/commit_if.sv
// commit_if: buffer snapshot in, register-file/release/store-memory ports out.
interface commit_if;
  import commit_pkg::*;
  entry_t [BUF_SIZE-1:0] entries_all;
  logic                  flush;
  logic [1:0]            reg_we;
  logic [1:0][4:0]       reg_waddr;
  logic [1:0][31:0]      reg_wdata;
  logic [1:0]            release_valid;
  index_t [1:0]          release_index;
  logic                  mem_req;
  logic [31:0]           mem_addr;
  logic [31:0]           mem_wdata;
  logic                  mem_ack;
  modport master (input entries_all, flush, mem_ack,
                  output reg_we, reg_waddr, reg_wdata, release_valid, release_index, mem_req, mem_addr, mem_wdata);
  modport slave (output entries_all, flush, mem_ack,
                 input reg_we, reg_waddr, reg_wdata, release_valid, release_index, mem_req, mem_addr, mem_wdata);
endinterface

// File: rtl/commit_finder.sv
// commit_finder: locates the live buffer entries carrying each of two tags.
module commit_finder import commit_pkg::*; (
  input  entry_t [BUF_SIZE-1:0] i_entries,
  input  tag_t [1:0]            i_tag,
  output logic [1:0]            o_found,
  output index_t [1:0]          o_index,
  output entry_t [1:0]          o_entry
);
  always_comb begin
    o_found = '0;
    o_index = '0;
    o_entry = '0;
    for (int i = 0; i < BUF_SIZE; i++)
      for (int j = 0; j < 2; j++)
        if (i_entries[i].e_state != S_NOT_USED && i_entries[i].tag == i_tag[j]) begin
          o_found[j] = 1'b1;
          o_index[j] = index_t'(i);
          o_entry[j] = i_entries[i];
        end
  end
endmodule

// File: rtl/commit.sv
// commit: in-order retirement of up to two entries per cycle, stores via a mem handshake.
module commit import commit_pkg::*; (
  input logic       clk,
  input logic       rst,
  commit_if.master  bus
);
  tag_t [1:0]       w_tag;
  logic [1:0]       w_found;
  index_t [1:0]     w_idx;
  entry_t [1:0]     w_ent;
  commit_state_t    r_state, w_state_nx;
  tag_t             r_head;
  index_t           r_st_idx;
  logic [31:0]      r_st_addr, r_st_data;
  logic             w_c0, w_st, w_r0, w_r1, w_ack, w_empty;
  logic [1:0]       w_ret, r_we, r_rv;
  logic [1:0][4:0]  r_waddr;
  logic [1:0][31:0] r_wdata;
  index_t [1:0]     r_ridx;
  assign w_tag = {r_head + tag_t'(1), r_head};
  commit_finder u_finder (
    .i_entries(bus.entries_all),
    .i_tag(w_tag),
    .o_found(w_found),
    .o_index(w_idx),
    .o_entry(w_ent)
  );
  always_comb begin
    w_empty = 1'b1;
    for (int i = 0; i < BUF_SIZE; i++) w_empty = w_empty && bus.entries_all[i].e_state == S_NOT_USED;
  end
  assign w_c0  = w_found[0] && retirable(w_ent[0]) && !bus.flush && r_state == IDLE;
  assign w_st  = w_c0 && w_ent[0].unit == STORE;
  assign w_r0  = w_c0 && w_ent[0].unit != STORE;
  assign w_r1  = w_r0 && w_found[1] && retirable(w_ent[1]) && w_ent[1].unit != STORE;
  assign w_ret = {w_r1, w_r0};
  assign w_ack = r_state == STORE_WAIT && bus.mem_ack;
  always_comb begin
    w_state_nx = r_state;
    if (w_st) w_state_nx = STORE_WAIT;
    else if (w_ack) w_state_nx = IDLE;
  end
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head    <= '0;
      r_we      <= '0;
      r_rv      <= '0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_ridx    <= '0;
      r_st_idx  <= '0;
      r_st_addr <= '0;
      r_st_data <= '0;
    end else begin
      // restart at tag 0 only once the buffer has seen every release
      r_head <= (w_empty && r_state == IDLE && !(|r_rv)) ? '0
              : r_head + tag_t'(w_r0) + tag_t'(w_r1) + tag_t'(w_ack);
      for (int k = 0; k < 2; k++) begin
        r_we[k]    <= w_ret[k] && w_ent[k].dest != 5'd0;
        r_waddr[k] <= w_ret[k] ? w_ent[k].dest : 5'd0;
        r_wdata[k] <= (w_ret[k] && w_ent[k].dest != 5'd0) ? w_ent[k].result : 32'd0;
      end
      r_rv      <= {w_r1, w_r0 || w_ack};
      r_ridx[0] <= w_r0 ? w_idx[0] : w_ack ? r_st_idx : '0;
      r_ridx[1] <= w_r1 ? w_idx[1] : '0;
      if (w_st) begin
        r_st_idx  <= w_idx[0];
        r_st_addr <= w_ent[0].result;
        r_st_data <= w_ent[0].vk;
      end else if (w_ack) begin
        r_st_idx  <= '0;
        r_st_addr <= '0;
        r_st_data <= '0;
      end
    end
  end
  assign bus.reg_we        = r_we;
  assign bus.reg_waddr     = r_waddr;
  assign bus.reg_wdata     = r_wdata;
  assign bus.release_valid = r_rv;
  assign bus.release_index = r_ridx;
  assign bus.mem_req       = r_state == STORE_WAIT;
  assign bus.mem_addr      = r_st_addr;
  assign bus.mem_wdata     = r_st_data;
endmodule

// File: tb/tb_commit.sv
// tb_commit: directed retirement, store handshake, wrap and reset checks for commit.
module tb_commit;
  import commit_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  commit_if ifc();
  commit dut (.clk(clk), .rst(rst), .bus(ifc));
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic clr();
    ifc.entries_all = '0;
  endtask
  function automatic entry_t mk(tag_t t, e_state_t s, unit_t u, logic [4:0] d,
                                logic [31:0] r, logic [31:0] v, logic [5:0] sp);
    mk = '{e_state: s, tag: t, speculative_tag: sp, unit: u, dest: d, result: r, vk: v};
  endfunction
  initial begin
    ifc.flush = 1'b0;
    ifc.mem_ack = 1'b0;
    clr();
    cyc(2);
    check("rst_we", ifc.reg_we, 0);
    check("rst_rv", ifc.release_valid, 0);
    check("rst_req", ifc.mem_req, 0);
    check("rst_addr", ifc.mem_addr, 0);
    check("rst_head", dut.r_head, 0);
    rst = 1'b0;
    // dual retire
    ifc.entries_all[0] = mk(0, S_EXECUTED, ALU, 3, 32'hA, 0, 0);
    ifc.entries_all[1] = mk(1, S_EXECUTED, ALU, 4, 32'hB, 0, 0);
    cyc();
    check("dual_we", ifc.reg_we, 2'b11);
    check("dual_wa0", ifc.reg_waddr[0], 3);
    check("dual_wa1", ifc.reg_waddr[1], 4);
    check("dual_wd0", ifc.reg_wdata[0], 32'hA);
    check("dual_wd1", ifc.reg_wdata[1], 32'hB);
    check("dual_rv", ifc.release_valid, 2'b11);
    check("dual_ri0", ifc.release_index[0], 0);
    check("dual_ri1", ifc.release_index[1], 1);
    check("dual_head", dut.r_head, 2);
    clr();
    cyc();
    check("pend_head", dut.r_head, 2);
    check("pend_we", ifc.reg_we, 0);
    cyc();
    check("empty_head", dut.r_head, 0);
    // only the older one executed
    ifc.entries_all[2] = mk(0, S_EXECUTED, ALU, 5, 32'h11, 0, 0);
    ifc.entries_all[3] = mk(1, S_WAITING, ALU, 6, 32'h22, 0, 0);
    cyc();
    check("one_we", ifc.reg_we, 2'b01);
    check("one_wa0", ifc.reg_waddr[0], 5);
    check("one_wd0", ifc.reg_wdata[0], 32'h11);
    check("one_rv", ifc.release_valid, 2'b01);
    check("one_ri0", ifc.release_index[0], 2);
    check("one_head", dut.r_head, 1);
    ifc.entries_all[2] = '0;
    cyc();
    check("notexec_rv", ifc.release_valid, 0);
    check("notexec_head", dut.r_head, 1);
    clr();
    cyc();
    check("clr_head", dut.r_head, 0);
    ifc.entries_all[1] = mk(1, S_EXECUTED, ALU, 7, 32'h77, 0, 0);
    cyc();
    check("c1only_rv", ifc.release_valid, 0);
    check("c1only_we", ifc.reg_we, 0);
    check("c1only_head", dut.r_head, 0);
    // flush, speculation, dest 0
    clr();
    ifc.entries_all[0] = mk(0, S_EXECUTED, ALU, 3, 32'h33, 0, 0);
    ifc.flush = 1'b1;
    cyc();
    check("flush_rv", ifc.release_valid, 0);
    check("flush_head", dut.r_head, 0);
    ifc.flush = 1'b0;
    ifc.entries_all[0] = mk(0, S_EXECUTED, ALU, 3, 32'h33, 0, 6'b000001);
    cyc();
    check("spec_rv", ifc.release_valid, 0);
    check("spec_head", dut.r_head, 0);
    ifc.entries_all[0] = mk(0, S_EXECUTED, ALU, 0, 32'h99, 0, 0);
    cyc();
    check("d0_rv", ifc.release_valid, 2'b01);
    check("d0_we", ifc.reg_we, 0);
    check("d0_ri0", ifc.release_index[0], 0);
    check("d0_head", dut.r_head, 1);
    clr();
    cyc(2);
    check("d0_empty_head", dut.r_head, 0);
    // store with ack on its third request cycle
    ifc.entries_all[0] = mk(0, S_EXECUTED, STORE, 0, 32'h100, 32'h55, 0);
    ifc.entries_all[1] = mk(1, S_EXECUTED, ALU, 4, 32'hB, 0, 0);
    cyc();
    check("st_rv", ifc.release_valid, 0);
    check("st_we", ifc.reg_we, 0);
    check("st_head", dut.r_head, 0);
    for (int k = 0; k < 3; k++) begin
      check("st_req", ifc.mem_req, 1);
      check("st_addr", ifc.mem_addr, 32'h100);
      check("st_data", ifc.mem_wdata, 32'h55);
      check("st_wait_rv", ifc.release_valid, 0);
      ifc.mem_ack = (k == 2);
      cyc();
    end
    ifc.mem_ack = 1'b0;
    check("ack_req", ifc.mem_req, 0);
    check("ack_rv", ifc.release_valid, 2'b01);
    check("ack_ri0", ifc.release_index[0], 0);
    check("ack_we", ifc.reg_we, 0);
    check("ack_addr", ifc.mem_addr, 0);
    check("ack_head", dut.r_head, 1);
    ifc.entries_all[0] = '0;
    cyc();
    check("post_we", ifc.reg_we, 2'b01);
    check("post_wd0", ifc.reg_wdata[0], 32'hB);
    check("post_ri0", ifc.release_index[0], 1);
    check("post_head", dut.r_head, 2);
    clr();
    cyc(2);
    check("st_empty_head", dut.r_head, 0);
    // walk head to 14, then wrap
    for (int k = 0; k < 7; k++) begin
      ifc.entries_all[0] = mk(tag_t'(2 * k), S_EXECUTED, ALU, 1, 32'(k), 0, 0);
      ifc.entries_all[1] = mk(tag_t'(2 * k + 1), S_EXECUTED, ALU, 2, 32'(k), 0, 0);
      cyc();
    end
    check("walk_head", dut.r_head, 14);
    ifc.entries_all[0] = mk(14, S_EXECUTED, ALU, 1, 32'hE, 0, 0);
    ifc.entries_all[1] = mk(15, S_EXECUTED, ALU, 2, 32'hF, 0, 0);
    cyc();
    check("wrap_we", ifc.reg_we, 2'b11);
    check("wrap_head", dut.r_head, 0);
    for (int k = 0; k < 2; k++) begin
      ifc.entries_all[0] = mk(tag_t'(2 * k), S_EXECUTED, ALU, 1, 0, 0, 0);
      ifc.entries_all[1] = mk(tag_t'(2 * k + 1), S_EXECUTED, ALU, 2, 0, 0, 0);
      cyc();
    end
    ifc.entries_all[0] = mk(4, S_EXECUTED, ALU, 1, 0, 0, 0);
    ifc.entries_all[1] = mk(5, S_WAITING, ALU, 2, 0, 0, 0);
    cyc();
    check("h5_head", dut.r_head, 5);
    cyc();
    check("h5_hold", dut.r_head, 5);
    clr();
    cyc();
    check("h5_empty_head", dut.r_head, 0);
    // reset while waiting on a store
    ifc.entries_all[0] = mk(0, S_EXECUTED, ALU, 1, 32'h1, 0, 0);
    ifc.entries_all[1] = mk(1, S_EXECUTED, STORE, 0, 32'h200, 32'h77, 0);
    cyc();
    check("nost1_rv", ifc.release_valid, 2'b01);
    check("nost1_head", dut.r_head, 1);
    cyc();
    check("st2_req", ifc.mem_req, 1);
    check("st2_addr", ifc.mem_addr, 32'h200);
    rst = 1'b1;
    cyc();
    check("rst_st_req", ifc.mem_req, 0);
    check("rst_st_addr", ifc.mem_addr, 0);
    check("rst_st_state", 32'(dut.r_state), 32'(IDLE));
    check("rst_st_head", dut.r_head, 0);
    check("rst_st_rv", ifc.release_valid, 0);
    rst = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/commit.md
COMMIT -- requirements
Module: commit

Interface
REQ-001 SHALL have parameters: none; uses BUF_SIZE, entry_t, tag_t, index_t from the shared package.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 entries_all  in  entry_t[BUF_SIZE]  current instruction-buffer contents.
REQ-006 flush  in  1  misprediction recovery in progress; inhibits retirement this cycle.
REQ-007 reg_we  out  1[2]  register-file write enables, port 0 is older.
REQ-008 reg_waddr  out  5[2]  write addresses.
REQ-009 reg_wdata  out  32[2]  write data (entry.result).
REQ-010 release_valid  out  1[2]  buffer entry to be set S_NOT_USED.
REQ-011 release_index  out  index_t[2]  index of released entry.
REQ-012 mem_req  out  1  store request; held until acknowledged.
REQ-013 mem_addr  out  32  store address (entry.result).
REQ-014 mem_wdata  out  32  store data (entry.Vk).
REQ-015 mem_ack  in  1  store accepted this cycle.

Function
REQ-016 SHALL hold head_tag (tag_t), the tag of the oldest unretired entry.
REQ-017 Candidate c0 = used entry (e_state != S_NOT_USED) with tag == head_tag; c1 = used entry with tag == head_tag+1 mod 16.
REQ-018 c0 retirable: found, e_state == S_EXECUTED, speculative_tag == 0, flush low, state IDLE.
REQ-019 c1 retirable: c0 retires non-store this cycle, c1 found, S_EXECUTED, speculative_tag == 0, Unit != STORE.
REQ-020 Retire of non-store: next cycle reg_we=1 iff Dest != 0, reg_waddr=Dest, reg_wdata=result, release_valid=1, release_index=entry index; outputs registered, latency 1 cycle.
REQ-021 head_tag SHALL advance by number retired (0,1,2), modulo 16 (1111 -> 0000, 1110+2 -> 0000).
REQ-022 FSM states IDLE, STORE_WAIT.
REQ-023 IDLE -> STORE_WAIT when c0 retirable with Unit == STORE; latch index, address, data; c1 not retired that cycle.
REQ-024 STORE_WAIT: mem_req=1 with latched addr/data stable; on mem_ack, next cycle release_valid[0]=1 with latched index, head_tag+1, -> IDLE; no reg write for stores.
REQ-025 flush SHALL not abort STORE_WAIT (store is non-speculative).
REQ-026 When every entry is S_NOT_USED, state IDLE and no release pending, head_tag SHALL load 0 (matches dispatch restarting tags at 0 on empty buffer).
REQ-027 Registered outputs not asserted in a cycle SHALL be 0 (valid/we low, addr/data 0).
REQ-028 If c0 absent or not executed, no retirement; c1 never retires ahead of c0.
REQ-029 BUF_SIZE SHALL be <= 16 so a tag never matches two live entries.

Reset
REQ-030 On rst: head_tag=0, state IDLE, reg_we, release_valid, mem_req all 0, all address/data/index outputs 0; a pending store is dropped.

Structure
REQ-031 entry_t, tag_t, index_t, BUF_SIZE, unit and e_state enums stay in the shared package; add commit_state_t there.
REQ-032 One sub-module commit_finder (combinational tag-match search returning found/index/entry for two tags).

Verification
REQ-033 head_tag=0, entries tags 0,1 executed ALU Dest 3,4 results 0xA,0xB -> next cycle reg_we=11, waddr 3/4, wdata 0xA/0xB, release both, head_tag=2.
REQ-034 Tag 0 executed, tag 1 not executed -> only port 0 retires, head_tag=1; tag 1 alone executed -> nothing retires.
REQ-035 Tag 0 STORE executed result 0x100 Vk 0x55, mem_ack after 3 cycles -> mem_req high 3 cycles with 0x100/0x55, release index next cycle, no reg write, head_tag=1.
REQ-036 head_tag=14, tags 14,15 executed -> head_tag=0; then buffer drained with head_tag=5 -> head_tag=0 once empty.
REQ-037 flush high or speculative_tag=6'b000001 on tag 0 -> no retirement; Dest=0 entry -> release only, reg_we=0.
REQ-038 rst asserted in STORE_WAIT -> next cycle mem_req=0, state IDLE, head_tag=0.
